// File: rtl/onewire_pkg.sv
// Shared 1-Wire definitions: default bus timing, reader FSM states and the Dallas CRC-8 step.
package onewire_pkg;

    // Default timing in clock ticks (1 tick = 1 us nominal).
    // The ROM sender and the reset/presence block use the same values.
    localparam int unsigned DEF_NUM_BITS = 64;
    localparam int unsigned DEF_T_LOW    = 8;
    localparam int unsigned DEF_T_SAMPLE = 20;
    localparam int unsigned DEF_T_SLOT   = 70;
    localparam int unsigned DEF_T_REC    = 4;

    // Slot counter width; it must hold T_SLOT-1 without wrapping.
    localparam int unsigned SLOT_CNT_W = 7;

    // Dallas/Maxim x^8+x^5+x^4+1, bit-reversed for LSB-first shifting.
    localparam logic [7:0] CRC_POLY_REFLECTED = 8'h8C;

    typedef enum logic [2:0] {
        StIdle,
        StSlotLow,
        StSlotWait,
        StSlotTail,
        StRecover,
        StCheck
    } state_e;

    // One serial CRC-8 update with the incoming bit.
    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic b);
        logic fb;
        fb = crc[0] ^ b;
        return (crc >> 1) ^ (fb ? CRC_POLY_REFLECTED : 8'h00);
    endfunction

endpackage

// File: rtl/onewire_rom_reader_if.sv
// Host/bus-facing signal bundle of the 1-Wire ROM reader.
// 'slave' is the reader's view; 'master' is the view of whoever drives start and the bus level.
interface onewire_rom_reader_if
    import onewire_pkg::*;
#(
    parameter int unsigned NUM_BITS = DEF_NUM_BITS
) ();

    logic                start;
    logic                bus_in;
    logic                bus_drive_low;
    logic [NUM_BITS-1:0] rom_out;
    logic                rom_valid;
    logic                crc_ok;
    logic                busy;
    logic                done;
    logic                bus_err;

    modport slave (
        input  start,
        input  bus_in,
        output bus_drive_low,
        output rom_out,
        output rom_valid,
        output crc_ok,
        output busy,
        output done,
        output bus_err
    );

    modport master (
        output start,
        output bus_in,
        input  bus_drive_low,
        input  rom_out,
        input  rom_valid,
        input  crc_ok,
        input  busy,
        input  done,
        input  bus_err
    );

endinterface

// File: rtl/onewire_crc8.sv
// Serial Dallas CRC-8, LSB first. Clear has priority over enable.
module onewire_crc8
    import onewire_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr_i,
    input  logic       en_i,
    input  logic       bit_i,
    output logic [7:0] crc_o
);

    logic [7:0] crc_q, crc_d;

    // Next CRC: clear, shift in one bit, or hold.
    always_comb begin
        crc_d = crc_q;
        if (clr_i) begin
            crc_d = 8'h00;
        end else if (en_i) begin
            crc_d = crc8_step(crc_q, bit_i);
        end
    end

    // CRC register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_q <= 8'h00;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc_o = crc_q;

endmodule

// File: rtl/onewire_rom_reader.sv
// 1-Wire master ROM reader: generates NUM_BITS read slots, assembles the ROM LSB first and
// checks the CRC-8 residue. All outputs are registered so the open-drain enable is glitch-free.
module onewire_rom_reader
    import onewire_pkg::*;
#(
    parameter int unsigned NUM_BITS = DEF_NUM_BITS,
    parameter int unsigned T_LOW    = DEF_T_LOW,     // >= 6 so the slave sees the slot
    parameter int unsigned T_SAMPLE = DEF_T_SAMPLE,  // > T_LOW
    parameter int unsigned T_SLOT   = DEF_T_SLOT,
    parameter int unsigned T_REC    = DEF_T_REC
) (
    input logic clk,
    input logic rst_n,
    onewire_rom_reader_if.slave bus
);

    localparam int unsigned IdxW = $clog2(NUM_BITS);
    localparam int unsigned RecW = $clog2(T_REC + 1);

    state_e                state_q;
    logic [SLOT_CNT_W-1:0] slot_cnt_q;
    logic [IdxW-1:0]       bit_idx_q;
    logic [RecW-1:0]       rec_cnt_q;
    logic [NUM_BITS-1:0]   rom_q;
    logic                  drive_low_q;
    logic                  rom_valid_q;
    logic                  crc_ok_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  bus_err_q;

    logic                  crc_clr;
    logic                  crc_en;
    logic [7:0]            crc;

    // CRC control: clear on an accepted start, shift at the sample point of each slot.
    always_comb begin
        crc_clr = 1'b0;
        crc_en  = 1'b0;
        if (state_q == StIdle && bus.start) begin
            crc_clr = 1'b1;
        end
        if (state_q == StSlotWait && slot_cnt_q == SLOT_CNT_W'(T_SAMPLE)) begin
            crc_en = 1'b1;
        end
    end

    onewire_crc8 u_crc8 (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (crc_clr),
        .en_i  (crc_en),
        .bit_i (bus.bus_in),
        .crc_o (crc)
    );

    // Slot sequencer with registered outputs; reset releases the bus asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            slot_cnt_q  <= '0;
            bit_idx_q   <= '0;
            rec_cnt_q   <= '0;
            rom_q       <= '0;
            drive_low_q <= 1'b0;
            rom_valid_q <= 1'b0;
            crc_ok_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            bus_err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        rom_valid_q <= 1'b0;
                        crc_ok_q    <= 1'b0;
                        bus_err_q   <= 1'b0;
                        bit_idx_q   <= '0;
                        rec_cnt_q   <= '0;
                        busy_q      <= 1'b1;
                        state_q     <= StRecover;
                    end
                end
                StRecover: begin
                    if (rec_cnt_q == RecW'(T_REC - 1)) begin
                        if (!bus.bus_in) begin
                            // Bus still low: abort without ever driving a slot.
                            bus_err_q <= 1'b1;
                            done_q    <= 1'b1;
                            busy_q    <= 1'b0;
                            state_q   <= StIdle;
                        end else begin
                            slot_cnt_q  <= '0;
                            drive_low_q <= 1'b1;
                            state_q     <= StSlotLow;
                        end
                    end else begin
                        rec_cnt_q <= rec_cnt_q + RecW'(1);
                    end
                end
                StSlotLow: begin
                    slot_cnt_q <= slot_cnt_q + SLOT_CNT_W'(1);
                    if (slot_cnt_q == SLOT_CNT_W'(T_LOW - 1)) begin
                        drive_low_q <= 1'b0;
                        state_q     <= StSlotWait;
                    end
                end
                StSlotWait: begin
                    slot_cnt_q <= slot_cnt_q + SLOT_CNT_W'(1);
                    if (slot_cnt_q == SLOT_CNT_W'(T_SAMPLE)) begin
                        rom_q[bit_idx_q] <= bus.bus_in;
                        state_q          <= StSlotTail;
                    end
                end
                StSlotTail: begin
                    if (slot_cnt_q == SLOT_CNT_W'(T_SLOT - 1)) begin
                        if (bit_idx_q == IdxW'(NUM_BITS - 1)) begin
                            // Results are presented during the CHECK cycle itself; the last
                            // CRC update happened at this slot's sample point.
                            crc_ok_q    <= (crc == 8'h00);
                            rom_valid_q <= 1'b1;
                            done_q      <= 1'b1;
                            busy_q      <= 1'b0;
                            state_q     <= StCheck;
                        end else begin
                            bit_idx_q <= bit_idx_q + IdxW'(1);
                            rec_cnt_q <= '0;
                            state_q   <= StRecover;
                        end
                    end else begin
                        slot_cnt_q <= slot_cnt_q + SLOT_CNT_W'(1);
                    end
                end
                StCheck: begin
                    state_q <= StIdle;
                end
                default: begin
                    drive_low_q <= 1'b0;
                    busy_q      <= 1'b0;
                    state_q     <= StIdle;
                end
            endcase
        end
    end

    assign bus.bus_drive_low = drive_low_q;
    assign bus.rom_out       = rom_q;
    assign bus.rom_valid     = rom_valid_q;
    assign bus.crc_ok        = crc_ok_q;
    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.bus_err       = bus_err_q;

endmodule

// File: tb/tb_onewire_rom_reader.sv
// Bench for onewire_rom_reader with a behavioural 1-Wire ROM slave.
module tb_onewire_rom_reader;

    // Start cycle counts as cycle 0; done is seen N-1 edges after the edge sampling start.
    localparam int LAT_READ  = 4737 - 1;
    localparam int LAT_ABORT = 5 - 1;
    localparam int WAIT_MAX  = 6000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    onewire_rom_reader_if ifc ();

    onewire_rom_reader dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc)
    );

    // Behavioural slave: on each master falling edge, pull low ~40 cycles if sending a 0.
    logic [63:0] slv_rom = 64'h0;
    logic        slv_clear = 1'b0;
    logic        hold_low = 1'b0;
    logic        drv_prev;
    logic        slv_bit;
    int          slv_idx;
    int          slv_cnt;
    int          done_cnt;
    int          drive_cycles;
    logic        slv_pull;

    assign slv_pull   = (slv_cnt != 0) && !slv_bit;
    assign ifc.bus_in = !(ifc.bus_drive_low || slv_pull || hold_low);

    always @(posedge clk) begin
        drv_prev <= ifc.bus_drive_low;
        if (!rst_n || slv_clear) begin
            slv_idx <= 0;
            slv_cnt <= 0;
            slv_bit <= 1'b1;
        end else if (ifc.bus_drive_low && !drv_prev) begin
            slv_cnt <= 1;
            slv_bit <= (slv_idx < 64) ? slv_rom[slv_idx] : 1'b1;
            slv_idx <= slv_idx + 1;
        end else if (slv_cnt != 0) begin
            slv_cnt <= (slv_cnt == 40) ? 0 : slv_cnt + 1;
        end
    end

    always @(posedge clk) begin
        if (slv_clear) begin
            done_cnt     <= 0;
            drive_cycles <= 0;
        end else begin
            if (ifc.done) done_cnt <= done_cnt + 1;
            if (ifc.bus_drive_low) drive_cycles <= drive_cycles + 1;
        end
    end

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Load the slave, clear monitors, pulse start; returns right after the sampling edge.
    task automatic begin_read(input logic [63:0] rom);
        @(negedge clk);
        slv_rom   = rom;
        slv_clear = 1'b1;
        @(negedge clk);
        slv_clear = 1'b0;
        ifc.start = 1'b1;
        @(posedge clk);
        #1 ifc.start = 1'b0;
    endtask

    task automatic wait_done(output int edges);
        edges = 0;
        while (edges < WAIT_MAX) begin
            @(posedge clk);
            #1 edges++;
            if (ifc.done) break;
        end
    endtask

    task automatic check_read(input string name, input logic [63:0] rom, input logic exp_crc);
        int edges;
        begin_read(rom);
        wait_done(edges);
        check({name, " latency"}, 64'(edges), 64'(LAT_READ));
        check({name, " rom_out"}, ifc.rom_out, rom);
        check({name, " rom_valid"}, 64'(ifc.rom_valid), 64'd1);
        check({name, " crc_ok"}, 64'(ifc.crc_ok), 64'(exp_crc));
        check({name, " bus_err"}, 64'(ifc.bus_err), 64'd0);
        check({name, " busy"}, 64'(ifc.busy), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        check({name, " done once"}, 64'(done_cnt), 64'd1);
        check({name, " done low"}, 64'(ifc.done), 64'd0);
    endtask

    typedef struct {
        string       name;
        logic [63:0] rom;
        logic        exp_crc_ok;
    } vec_t;

    vec_t vecs[4];

    initial begin
        int edges;

        vecs[0] = '{name: "good_rom",   rom: 64'hA200_0000_01B8_1C02, exp_crc_ok: 1'b1};
        vecs[1] = '{name: "zero_rom",   rom: 64'h0000_0000_0000_0000, exp_crc_ok: 1'b1};
        vecs[2] = '{name: "bit0_flip",  rom: 64'hA200_0000_01B8_1C03, exp_crc_ok: 1'b0};
        vecs[3] = '{name: "bit63_flip", rom: 64'h2200_0000_01B8_1C02, exp_crc_ok: 1'b0};

        ifc.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst drive_low", 64'(ifc.bus_drive_low), 64'd0);
        check("rst rom_out", ifc.rom_out, 64'd0);
        check("rst rom_valid", 64'(ifc.rom_valid), 64'd0);
        check("rst crc_ok", 64'(ifc.crc_ok), 64'd0);
        check("rst busy", 64'(ifc.busy), 64'd0);
        check("rst done", 64'(ifc.done), 64'd0);
        check("rst bus_err", 64'(ifc.bus_err), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 4; i++) begin
            check_read(vecs[i].name, vecs[i].rom, vecs[i].exp_crc_ok);
        end

        // Bus held low at start: abort after recovery, no slot ever driven.
        hold_low = 1'b1;
        begin_read(64'h0);
        wait_done(edges);
        check("abort latency", 64'(edges), 64'(LAT_ABORT));
        check("abort bus_err", 64'(ifc.bus_err), 64'd1);
        check("abort rom_valid", 64'(ifc.rom_valid), 64'd0);
        check("abort busy", 64'(ifc.busy), 64'd0);
        repeat (5) @(posedge clk);
        #1;
        check("abort no drive", 64'(drive_cycles), 64'd0);
        check("abort err sticky", 64'(ifc.bus_err), 64'd1);
        hold_low = 1'b0;

        // Reset while driving low in slot 10 (slot 10 low phase spans edges 744..751).
        begin_read(vecs[0].rom);
        repeat (746) @(posedge clk);
        #1;
        check("slot10 driving", 64'(ifc.bus_drive_low), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("midrst drive_low", 64'(ifc.bus_drive_low), 64'd0);
        check("midrst rom_out", ifc.rom_out, 64'd0);
        check("midrst rom_valid", 64'(ifc.rom_valid), 64'd0);
        check("midrst busy", 64'(ifc.busy), 64'd0);
        check("midrst done", 64'(ifc.done), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check_read("after_rst", vecs[0].rom, 1'b1);

        // Start pulsed again during slot 5 must be ignored.
        begin_read(vecs[2].rom);
        edges = 0;
        while (edges < WAIT_MAX) begin
            @(posedge clk);
            #1 edges++;
            if (edges == 400) ifc.start = 1'b1;
            if (edges == 401) ifc.start = 1'b0;
            if (ifc.done) break;
        end
        check("busy_start latency", 64'(edges), 64'(LAT_READ));
        check("busy_start rom_out", ifc.rom_out, vecs[2].rom);
        check("busy_start crc_ok", 64'(ifc.crc_ok), 64'd0);
        repeat (10) @(posedge clk);
        #1;
        check("busy_start done once", 64'(done_cnt), 64'd1);
        check("busy_start idle", 64'(ifc.busy), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
